// File: rtl/adder_error_monitor.sv
// Error-statistics stage for a 16-bit approximate adder: exact sum, error distance, run counters.
// Optional per-bit mismatch counters are built when ERR_BITFLIP_EN is defined.
module adder_error_monitor #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 17,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_samples,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        op_a,
    input  logic [IN_W-1:0]        op_b,
    input  logic [OUT_W-1:0]       approx_sum,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       sample_count,
    output logic [CNT_W-1:0]       error_count,
    output logic [OUT_W-1:0]       max_ed,
    output logic [ACC_W-1:0]       sum_ed
`ifdef ERR_BITFLIP_EN
    ,
    output logic [OUT_W*CNT_W-1:0] bitflip_count
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] accepted_q, num_q;
    logic             start_acc, xfer, pipe_empty;

    logic             vld_p0, vld_p1;
    logic [IN_W-1:0]  a_p0, b_p0;
    logic [OUT_W-1:0] s_p0;
    logic [OUT_W-1:0] exact_c, ed_c, ed_p1;
    logic             err_p1;

    logic [CNT_W-1:0] sample_q, error_q;
    logic [OUT_W-1:0] max_q;
    logic [ACC_W-1:0] sum_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && !(&v)) ? v + CNT_W'(1) : v;
    endfunction

    function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] acc,
                                                  input logic [OUT_W-1:0] ed);
        logic [ACC_W:0] s;
        s = {1'b0, acc} + (ACC_W+1)'(ed);
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] abs_diff(input logic [OUT_W-1:0] x,
                                                   input logic [OUT_W-1:0] y);
        logic signed [OUT_W:0] d;
        d = $signed({1'b0, x}) - $signed({1'b0, y});
        return d[OUT_W] ? OUT_W'(-d) : d[OUT_W-1:0];
    endfunction

    assign start_acc  = start && (state_q == S_IDLE || state_q == S_DONE);
    assign xfer       = in_valid && in_ready;
    assign pipe_empty = !vld_p0 && !vld_p1;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = (num_samples == '0) ? S_DONE : S_RUN;
            S_RUN:          if (xfer && accepted_q == num_q - CNT_W'(1)) state_d = S_DRAIN;
            S_DRAIN:        if (pipe_empty) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_RUN) && (accepted_q < num_q);
        busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
        done     = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            accepted_q <= '0;
            num_q      <= '0;
        end else if (start_acc) begin
            accepted_q <= '0;
            num_q      <= num_samples;
        end else if (xfer) begin
            accepted_q <= accepted_q + CNT_W'(1);
        end
    end

    // Stage 0: register the accepted beat
    always_ff @(posedge clk) begin
        if (rst) vld_p0 <= 1'b0;
        else     vld_p0 <= xfer;
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            a_p0 <= op_a;
            b_p0 <= op_b;
            s_p0 <= approx_sum;
        end
    end

    // Stage 1: exact sum, error distance, mismatch mask
    assign exact_c = OUT_W'(a_p0) + OUT_W'(b_p0);
    assign ed_c    = abs_diff(exact_c, s_p0);

    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= vld_p0;
    end

    always_ff @(posedge clk) begin
        if (vld_p0) begin
            ed_p1  <= ed_c;
            err_p1 <= (ed_c != '0);
        end
    end

    // Stage 2: saturating statistics
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            sample_q <= '0;
            error_q  <= '0;
            max_q    <= '0;
            sum_q    <= '0;
        end else if (vld_p1) begin
            sample_q <= sat_inc(sample_q, 1'b1);
            error_q  <= sat_inc(error_q, err_p1);
            if (ed_p1 > max_q) max_q <= ed_p1;
            sum_q    <= sat_acc(sum_q, ed_p1);
        end
    end

    assign sample_count = sample_q;
    assign error_count  = error_q;
    assign max_ed       = max_q;
    assign sum_ed       = sum_q;

`ifdef ERR_BITFLIP_EN
    logic [OUT_W-1:0] mis_p1;
    logic [CNT_W-1:0] flip_q [OUT_W];

    always_ff @(posedge clk) begin
        if (vld_p0) mis_p1 <= exact_c ^ s_p0;
    end

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            for (int i = 0; i < OUT_W; i++) flip_q[i] <= '0;
        end else if (vld_p1) begin
            for (int i = 0; i < OUT_W; i++) flip_q[i] <= sat_inc(flip_q[i], mis_p1[i]);
        end
    end

    always_comb begin
        bitflip_count = '0;
        for (int i = 0; i < OUT_W; i++) bitflip_count[i*CNT_W +: CNT_W] = flip_q[i];
    end
`endif

endmodule

// File: tb/tb_adder_error_monitor.sv
// Bench for adder_error_monitor: randomized and directed runs checked by a scoreboard
// fed from a behavioural model of the error statistics.
module tb_adder_error_monitor;
    localparam int IN_W  = 16;
    localparam int OUT_W = 17;
    localparam int CNT_W = 32;
    localparam int ACC_W = 20;
    localparam longint unsigned SUM_MAX = (64'd1 << ACC_W) - 1;
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, start, in_valid;
    logic [CNT_W-1:0] num_samples;
    logic [IN_W-1:0]  op_a, op_b;
    logic [OUT_W-1:0] approx_sum;
    logic             in_ready, busy, done;
    logic [CNT_W-1:0] sample_count, error_count;
    logic [OUT_W-1:0] max_ed;
    logic [ACC_W-1:0] sum_ed;
`ifdef ERR_BITFLIP_EN
    logic [OUT_W*CNT_W-1:0] bitflip_count;
`endif

    adder_error_monitor #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b),
        .approx_sum(approx_sum), .busy(busy), .done(done),
        .sample_count(sample_count), .error_count(error_count),
        .max_ed(max_ed), .sum_ed(sum_ed)
`ifdef ERR_BITFLIP_EN
        , .bitflip_count(bitflip_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int              due;
        longint unsigned cnt, err, mx, sm;
    } exp_t;
    exp_t sb[$];

    longint unsigned m_cnt, m_err, m_max, m_sum;
`ifdef ERR_BITFLIP_EN
    longint unsigned m_flip[OUT_W];
`endif
    int last_xfer_cyc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic model_start();
        m_cnt = 0; m_err = 0; m_max = 0; m_sum = 0;
`ifdef ERR_BITFLIP_EN
        for (int i = 0; i < OUT_W; i++) m_flip[i] = 0;
`endif
    endtask

    task automatic model_beat(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                              input logic [OUT_W-1:0] s);
        longint ex, ap, ed;
        ex = longint'(a) + longint'(b);
        ap = longint'(s);
        ed = (ex > ap) ? ex - ap : ap - ex;
        if (m_cnt < CNT_MAX) m_cnt++;
        if (ed != 0 && m_err < CNT_MAX) m_err++;
        if (longint'(m_max) < ed) m_max = ed;
        m_sum = (m_sum + ed > SUM_MAX) ? SUM_MAX : m_sum + ed;
`ifdef ERR_BITFLIP_EN
        for (int i = 0; i < OUT_W; i++)
            if (((ex ^ ap) >> i) & 1) m_flip[i]++;
`endif
    endtask

    // Called at a falling edge; a beat presented while in_ready is high transfers on the next rise.
    task automatic drive(input logic v, input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                         input logic [OUT_W-1:0] s);
        in_valid = v; op_a = a; op_b = b; approx_sum = s;
        if (v && in_ready) begin
            model_beat(a, b, s);
            sb.push_back('{cyc + 3, m_cnt, m_err, m_max, m_sum});
            last_xfer_cyc = cyc;
        end
        @(negedge clk);
    endtask

    task automatic do_start(input logic [CNT_W-1:0] n);
        start = 1'b1; num_samples = n; in_valid = 1'b0;
        model_start();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_final(input string tag);
        chk({tag, "_samples"}, sample_count, m_cnt);
        chk({tag, "_errors"},  error_count,  m_err);
        chk({tag, "_max_ed"},  max_ed,       m_max);
        chk({tag, "_sum_ed"},  sum_ed,       m_sum);
`ifdef ERR_BITFLIP_EN
        for (int i = 0; i < OUT_W; i++)
            chk($sformatf("%s_flip%0d", tag, i), bitflip_count[i*CNT_W +: CNT_W], m_flip[i]);
`endif
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_done_latency"}, cyc, last_xfer_cyc + 4);
        chk({tag, "_busy_low"}, busy, 0);
        chk({tag, "_sb_drained"}, sb.size(), 0);
        chk_final(tag);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_samples"}, sample_count, 0);
        chk({tag, "_errors"}, error_count, 0);
        chk({tag, "_max_ed"}, max_ed, 0);
        chk({tag, "_sum_ed"}, sum_ed, 0);
`ifdef ERR_BITFLIP_EN
        chk({tag, "_flips"}, bitflip_count == '0, 1);
`endif
    endtask

    // Monitor: compare live statistics when each beat's contribution is due.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("live_samples", sample_count, e.cnt);
            chk("live_errors",  error_count,  e.err);
            chk("live_max_ed",  max_ed,       e.mx);
            chk("live_sum_ed",  sum_ed,       e.sm);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IN_W-1:0]  ra, rb;
        logic [OUT_W-1:0] rs;
        int               guard;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_samples = '0;
        op_a = '0; op_b = '0; approx_sum = '0;
        model_start();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // exact adder: no errors
        do_start(4);
        chk("exact_in_ready_rise", in_ready, 1);
        chk("exact_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            ra = IN_W'(i + 1); rb = IN_W'(i + 2);
            drive(1'b1, ra, rb, OUT_W'(ra) + OUT_W'(rb));
            if (i == 1) drive(1'b0, '0, '0, '0);
        end
        in_valid = 1'b0;
        wait_done("exact");
        chk("exact_sample_const", sample_count, 4);
        chk("exact_sum_const", sum_ed, 0);
        repeat (2) @(negedge clk);
        chk("exact_done_level", done, 1);

        // MSB-only model, beats 1 and 3 repeated
        do_start(5);
        drive(1'b1, 16'hFFFF, 16'h0001, 17'h10000);
        drive(1'b1, 16'h8000, 16'h8000, 17'h10000);
        drive(1'b1, 16'h1234, 16'h0001, 17'h00000);
        drive(1'b1, 16'hFFFF, 16'h0001, 17'h10000);
        drive(1'b1, 16'h1234, 16'h0001, 17'h00000);
        in_valid = 1'b0;
        wait_done("msb");
        chk("msb_err_const", error_count, 2);
        chk("msb_max_const", max_ed, 17'h1235);
        chk("msb_sum_const", sum_ed, 20'h246A);

        // accumulator saturation
        do_start(9);
        for (int i = 0; i < 9; i++) drive(1'b1, '0, '0, 17'h1FFFF);
        in_valid = 1'b0;
        wait_done("sat");
        chk("sat_sum_allones", sum_ed, SUM_MAX);
        chk("sat_max", max_ed, 17'h1FFFF);

        // zero-length run
        do_start(0);
        chk("zero_done", done, 1);
        chk("zero_samples", sample_count, 0);
        chk("zero_sum", sum_ed, 0);
        chk("zero_max", max_ed, 0);
        for (int i = 0; i < 3; i++) begin
            chk("zero_in_ready", in_ready, 0);
            @(negedge clk);
        end

        // randomized run with bubbles
        do_start(24);
        guard = 0;
        while (m_cnt < 24 && guard < 300) begin
            ra = IN_W'($urandom); rb = IN_W'($urandom);
            case ($urandom_range(0, 2))
                0:       rs = OUT_W'(ra) + OUT_W'(rb);
                1:       rs = (OUT_W'(ra) + OUT_W'(rb)) ^ OUT_W'($urandom_range(0, 255));
                default: rs = OUT_W'($urandom);
            endcase
            drive($urandom_range(0, 3) != 0, ra, rb, rs);
            guard++;
        end
        in_valid = 1'b0;
        wait_done("rand");

        // reset mid-run with two beats in flight
        do_start(10);
        for (int i = 0; i < 5; i++) drive(1'b1, IN_W'($urandom), IN_W'($urandom), OUT_W'($urandom));
        rst = 1'b1; in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk_zero("midreset");
        rst = 1'b0;
        @(negedge clk);
        chk_zero("midreset_idle");
        do_start(3);
        for (int i = 0; i < 3; i++) drive(1'b1, 16'h00F0, 16'h000F, 17'h000F0);
        in_valid = 1'b0;
        wait_done("after_reset");
        chk("after_reset_samples", sample_count, 3);

        // protocol: start ignored in RUN, valid held past the end
        do_start(6);
        for (int i = 0; i < 2; i++) drive(1'b1, IN_W'($urandom), IN_W'($urandom), OUT_W'($urandom));
        start = 1'b1; num_samples = 2;
        drive(1'b0, '0, '0, '0);
        start = 1'b0;
        chk("proto_start_ignored_ready", in_ready, 1);
        guard = 0;
        while (in_ready && guard < 30) begin
            drive(1'b1, IN_W'($urandom), IN_W'($urandom), OUT_W'($urandom));
            guard++;
        end
        chk("proto_ready_dropped", in_ready, 0);
        wait_done("proto");
        chk("proto_samples", sample_count, 6);
        repeat (3) @(negedge clk);
        chk("proto_no_extra", sample_count, 6);
        chk("proto_ready_low", in_ready, 0);
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
